// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches and buffers {pc, word} pairs for decode.
// Latency: a request reaches out_valid 2 cycles later; streams one instruction per cycle.
// Backpressure: out_ready=0 fills the queue and fetching stops once queue + inflight reaches DEPTH.
// Optional feature: define IFQ_STALL_CNT_EN to add the stall_cnt output (cycles with no head entry).
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef IFQ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Fetch-side state
  logic [31:0]   fetch_pc;
  logic          inflight;      // a request was issued last cycle
  logic [31:0]   inflight_pc;   // address of that request
  logic          kill_q;        // response arriving this cycle belongs to a flushed path

  // Queue storage and bookkeeping
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [CW:0]   occupancy;
  logic          head_vld;
  logic          push;
  logic          pop;

  // Low address bits of a redirect are ignored: instructions are word aligned.
  logic          unused_redir_lsb;
  assign unused_redir_lsb = &{1'b0, redir_pc[1:0]};

  // Slots already promised: queued entries plus the response still on its way back.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign head_vld  = (count != '0);

  // Request only when a slot is guaranteed; never on a redirect cycle or in reset.
  assign imem_req  = !rst && !redir_valid && (occupancy < DEPTH_C);
  assign imem_addr = fetch_pc;

  // Responses are dropped if killed by last cycle's redirect, or flushed by this cycle's.
  assign push      = inflight && !kill_q && !redir_valid && !rst;

  // Head presentation; zero when empty or in reset so decode never sees stale data.
  assign out_valid = !rst && head_vld;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign pop       = out_valid && out_ready;

  // Fetch PC: reset vector, redirect target (word aligned), or sequential +4.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
    end else if (redir_valid) begin
      fetch_pc <= {redir_pc[31:2], 2'b00};
    end else if (imem_req) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Track the outstanding request and whether its response must be discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      kill_q      <= 1'b0;
    end else begin
      inflight    <= imem_req;
      inflight_pc <= fetch_pc;
      kill_q      <= redir_valid;
    end
  end

  // Queue payload write; storage needs no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

  // Pointers and occupancy; a redirect empties the queue regardless of push/pop.
  always_ff @(posedge clk) begin
    if (rst || redir_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IFQ_STALL_CNT_EN
  // Saturating count of cycles where decode had nothing to take.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'h0;
    end else if (!out_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
